// File: rtl/game_flow_sequencer_if.sv
// Tile-map loader handshake between the game-flow sequencer
// (master) and the map loader (slave).
interface game_flow_sequencer_if;
    logic       loadReq;
    logic [2:0] levelNum;
    logic       loadDone;
    logic [5:0] giftsTotal;

    modport master (
        output loadReq,
        output levelNum,
        input  loadDone,
        input  giftsTotal
    );

    modport slave (
        input  loadReq,
        input  levelNum,
        output loadDone,
        output giftsTotal
    );
endinterface

// File: rtl/game_flow_sequencer.sv
// Bumpy game-flow controller: start, load, play, life loss,
// level completion, game over and victory sequencing.
module game_flow_sequencer #(
    parameter int START_LIVES    = 3,
    parameter int NUM_LEVELS     = 4,
    parameter int LEVEL_TIME_SEC = 60,
    parameter int FRAMES_PER_SEC = 30,
    parameter int MSG_FRAMES     = 60
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  startKey,
    input  logic                  giftTaken,
    input  logic                  holeHit,
    input  logic                  fallOut,
    game_flow_sequencer_if.master ldr,
    output logic [1:0]            lives,
    output logic [5:0]            giftsLeft,
    output logic [6:0]            timeLeft,
    output logic                  showHole,
    output logic                  freezeN,
    output logic [2:0]            gameState
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_PLAY       = 3'd2;
    localparam logic [2:0] S_LOST_LIFE  = 3'd3;
    localparam logic [2:0] S_LEVEL_DONE = 3'd4;
    localparam logic [2:0] S_GAME_OVER  = 3'd5;
    localparam logic [2:0] S_VICTORY    = 3'd6;

    localparam int FCW = (FRAMES_PER_SEC > 1) ?
                         $clog2(FRAMES_PER_SEC) : 1;
    localparam int MCW = (MSG_FRAMES > 1) ?
                         $clog2(MSG_FRAMES) : 1;

    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_SEC - 1);
    localparam logic [MCW-1:0] MSG_LAST   = MCW'(MSG_FRAMES - 1);
    localparam logic [1:0]     LIVES_INIT = 2'(START_LIVES);
    localparam logic [6:0]     TIME_INIT  = 7'(LEVEL_TIME_SEC);
    localparam logic [2:0]     LEVEL_LAST = 3'(NUM_LEVELS - 1);

    logic [2:0]     state;
    logic           key_q;
    logic           armed;
    logic           gift_flag;
    logic [FCW-1:0] frame_cnt;
    logic [MCW-1:0] msg_cnt;
    logic [2:0]     level;
    logic [1:0]     lives_q;
    logic [5:0]     gifts_q;
    logic [6:0]     time_q;

    logic key_rise;
    logic hole_open;
    logic msg_end;
    logic gift_hit;

    // armed keeps a key held through reset from looking like an edge
    assign key_rise  = startKey & ~key_q & armed;
    assign hole_open = (state == S_PLAY) && (gifts_q == 6'd0);
    assign msg_end   = startOfFrame && (msg_cnt == MSG_LAST);
    assign gift_hit  = giftTaken && (startOfFrame || !gift_flag);

    assign ldr.loadReq  = (state == S_LOAD);
    assign ldr.levelNum = level;
    assign lives        = lives_q;
    assign giftsLeft    = gifts_q;
    assign timeLeft     = time_q;
    assign showHole     = hole_open;
    assign freezeN      = (state == S_PLAY);
    assign gameState    = state;

    // game-flow state machine and the counters it owns
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            key_q     <= 1'b0;
            armed     <= 1'b0;
            gift_flag <= 1'b0;
            frame_cnt <= '0;
            msg_cnt   <= '0;
            level     <= 3'd0;
            lives_q   <= 2'd0;
            gifts_q   <= 6'd0;
            time_q    <= 7'd0;
        end else begin
            key_q <= startKey;
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (key_rise) begin
                        level   <= 3'd0;
                        lives_q <= LIVES_INIT;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ldr.loadDone) begin
                        gifts_q   <= ldr.giftsTotal;
                        time_q    <= TIME_INIT;
                        frame_cnt <= '0;
                        gift_flag <= 1'b0;
                        state     <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    // a frame start re-arms the flag, same-cycle gift counts
                    if (startOfFrame) begin
                        gift_flag <= giftTaken;
                    end else if (giftTaken) begin
                        gift_flag <= 1'b1;
                    end
                    if (gift_hit && gifts_q != 6'd0) begin
                        gifts_q <= gifts_q - 6'd1;
                    end
                    if (startOfFrame) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            if (time_q != 7'd0) begin
                                time_q <= time_q - 7'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    if (holeHit && hole_open) begin
                        msg_cnt <= '0;
                        state   <= S_LEVEL_DONE;
                    end else if (fallOut || time_q == 7'd0) begin
                        msg_cnt <= '0;
                        state   <= S_LOST_LIFE;
                        if (lives_q != 2'd0) begin
                            lives_q <= lives_q - 2'd1;
                        end
                    end
                end
                S_LOST_LIFE: begin
                    if (msg_end) begin
                        state <= (lives_q == 2'd0) ?
                                 S_GAME_OVER : S_LOAD;
                    end else if (startOfFrame) begin
                        msg_cnt <= msg_cnt + 1'b1;
                    end
                end
                S_LEVEL_DONE: begin
                    if (msg_end) begin
                        if (level == LEVEL_LAST) begin
                            state <= S_VICTORY;
                        end else begin
                            level <= level + 3'd1;
                            state <= S_LOAD;
                        end
                    end else if (startOfFrame) begin
                        msg_cnt <= msg_cnt + 1'b1;
                    end
                end
                S_GAME_OVER, S_VICTORY: begin
                    if (key_rise) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Directed bench for game_flow_sequencer: vector table for the
// start/load/gift path plus hand sequences for multi-frame cases.
module tb_game_flow_sequencer;

    typedef struct {
        logic [5:0]  in;
        logic [5:0]  total;
        logic [23:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0;
    logic       key = 1'b0;
    logic       gift = 1'b0;
    logic       hole = 1'b0;
    logic       fall = 1'b0;
    logic [1:0] lives;
    logic [5:0] giftsLeft;
    logic [6:0] timeLeft;
    logic       showHole;
    logic       freezeN;
    logic [2:0] gameState;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vecs[12];

    game_flow_sequencer_if ldr();

    game_flow_sequencer #(
        .START_LIVES    (3),
        .NUM_LEVELS     (4),
        .LEVEL_TIME_SEC (2),
        .FRAMES_PER_SEC (3),
        .MSG_FRAMES     (60)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (sof),
        .startKey     (key),
        .giftTaken    (gift),
        .holeHit      (hole),
        .fallOut      (fall),
        .ldr          (ldr),
        .lives        (lives),
        .giftsLeft    (giftsLeft),
        .timeLeft     (timeLeft),
        .showHole     (showHole),
        .freezeN      (freezeN),
        .gameState    (gameState)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ex(
        int st, int req, int lv, int lvl,
        int gl, int tl, int sh, int fz
    );
        return {3'(st), 1'(req), 2'(lv), 3'(lvl),
                6'(gl), 7'(tl), 1'(sh), 1'(fz)};
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic frames(int n);
        repeat (n) begin
            sof = 1'b1;
            @(negedge clk);
            sof = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_done(int total);
        ldr.loadDone   = 1'b1;
        ldr.giftsTotal = 6'(total);
        @(negedge clk);
        ldr.loadDone = 1'b0;
    endtask

    task automatic key_edge();
        key = 1'b1;
        @(negedge clk);
        key = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_hole();
        hole = 1'b1;
        @(negedge clk);
        hole = 1'b0;
    endtask

    task automatic pulse_fall();
        fall = 1'b1;
        @(negedge clk);
        fall = 1'b0;
    endtask

    initial begin
        logic [23:0] got;
        ldr.loadDone   = 1'b0;
        ldr.giftsTotal = 6'd0;

        // in = {sof, key, gift, hole, fall, done}
        vecs[0]  = '{6'b000000, 6'd0, ex(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{6'b010000, 6'd0, ex(1, 1, 3, 0, 0, 0, 0, 0)};
        vecs[2]  = '{6'b010000, 6'd0, ex(1, 1, 3, 0, 0, 0, 0, 0)};
        vecs[3]  = '{6'b000001, 6'd2, ex(2, 0, 3, 0, 2, 2, 0, 1)};
        vecs[4]  = '{6'b001000, 6'd0, ex(2, 0, 3, 0, 1, 2, 0, 1)};
        vecs[5]  = '{6'b001000, 6'd0, ex(2, 0, 3, 0, 1, 2, 0, 1)};
        vecs[6]  = '{6'b001000, 6'd0, ex(2, 0, 3, 0, 1, 2, 0, 1)};
        vecs[7]  = '{6'b100000, 6'd0, ex(2, 0, 3, 0, 1, 2, 0, 1)};
        vecs[8]  = '{6'b000100, 6'd0, ex(2, 0, 3, 0, 1, 2, 0, 1)};
        vecs[9]  = '{6'b101000, 6'd0, ex(2, 0, 3, 0, 0, 2, 1, 1)};
        vecs[10] = '{6'b001000, 6'd0, ex(2, 0, 3, 0, 0, 2, 1, 1)};
        vecs[11] = '{6'b000110, 6'd0, ex(4, 0, 3, 0, 0, 2, 0, 0)};

        repeat (3) @(negedge clk);
        got = {gameState, ldr.loadReq, lives, ldr.levelNum,
               giftsLeft, timeLeft, showHole, freezeN};
        chk("reset_outputs", int'(got), int'(ex(0, 0, 0, 0, 0, 0, 0, 0)));
        resetN = 1'b1;

        for (int i = 0; i < 12; i++) begin
            {sof, key, gift, hole, fall, ldr.loadDone} = vecs[i].in;
            ldr.giftsTotal = vecs[i].total;
            @(negedge clk);
            got = {gameState, ldr.loadReq, lives, ldr.levelNum,
                   giftsLeft, timeLeft, showHole, freezeN};
            n_vec++;
            if (got !== vecs[i].exp) begin
                n_bad++;
                $display("FAIL vec[%0d]: got %h expected %h",
                         i, got, vecs[i].exp);
            end
        end
        {sof, key, gift, hole, fall, ldr.loadDone} = 6'b0;

        // level 0 completion message, then level 1
        frames(59);
        chk("done_msg_59", int'(gameState), 4);
        frames(1);
        chk("done_msg_60", int'(gameState), 1);
        chk("level_1", int'(ldr.levelNum), 1);
        chk("req_level_1", int'(ldr.loadReq), 1);

        pulse_done(2);
        chk("l1_gifts", int'(giftsLeft), 2);
        gift = 1'b1;
        repeat (500) @(negedge clk);
        gift = 1'b0;
        chk("gift_hold_1", int'(giftsLeft), 1);
        sof  = 1'b1;
        gift = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        repeat (499) @(negedge clk);
        gift = 1'b0;
        chk("gift_hold_2", int'(giftsLeft), 0);
        chk("hole_shown", int'(showHole), 1);
        pulse_hole();
        chk("l1_done", int'(gameState), 4);
        frames(60);
        chk("level_2", int'(ldr.levelNum), 2);

        pulse_done(0);
        pulse_hole();
        frames(60);
        chk("level_3", int'(ldr.levelNum), 3);

        pulse_done(0);
        pulse_hole();
        chk("l3_done", int'(gameState), 4);
        frames(59);
        chk("l3_msg_59", int'(gameState), 4);
        frames(1);
        chk("victory", int'(gameState), 6);
        chk("victory_lives", int'(lives), 3);
        chk("victory_frozen", int'(freezeN), 0);

        key_edge();
        chk("victory_to_idle", int'(gameState), 0);
        key_edge();
        chk("restart_load", int'(gameState), 1);
        chk("restart_level", int'(ldr.levelNum), 0);

        // three lost lives lead to game over
        for (int k = 0; k < 3; k++) begin
            pulse_done(5);
            pulse_fall();
            chk("fall_state", int'(gameState), 3);
            chk("fall_lives", int'(lives), 2 - k);
            if (k < 2) begin
                frames(60);
                chk("fall_reload", int'(gameState), 1);
            end
        end
        pulse_done(9);
        chk("done_outside_load", int'(giftsLeft), 5);
        frames(59);
        chk("lost_msg_59", int'(gameState), 3);
        frames(1);
        chk("game_over", int'(gameState), 5);

        key_edge();
        key_edge();
        chk("restart2_lives", int'(lives), 3);

        // timeout with 2 s x 3 frames
        pulse_done(5);
        chk("time_init", int'(timeLeft), 2);
        frames(5);
        chk("time_after_5", int'(timeLeft), 1);
        chk("play_after_5", int'(gameState), 2);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        chk("time_zero", int'(timeLeft), 0);
        chk("play_at_zero", int'(gameState), 2);
        @(negedge clk);
        chk("timeout_lost", int'(gameState), 3);
        chk("timeout_lives", int'(lives), 2);

        // asynchronous reset mid-handshake with key held
        frames(60);
        chk("pre_reset_req", int'(ldr.loadReq), 1);
        key = 1'b1;
        @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        got = {gameState, ldr.loadReq, lives, ldr.levelNum,
               giftsLeft, timeLeft, showHole, freezeN};
        chk("async_reset", int'(got), int'(ex(0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_key_no_start", int'(gameState), 0);
        key = 1'b0;
        @(negedge clk);
        key = 1'b1;
        @(negedge clk);
        chk("start_after_reset", int'(gameState), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
